// File: rtl/popcount_acc7_if.sv
// Handshake bundle for popcount_acc7: upstream XNOR beats in, frame result out.
// The master side is whoever drives the beats and consumes the result.
interface popcount_acc7_if #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 8,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic [ACC_W-1:0] threshold;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_bit;
  logic [CNT_W-1:0] out_beats;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, threshold, out_ready,
    input  in_ready, out_valid, out_sum, out_bit, out_beats, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, threshold, out_ready,
    output in_ready, out_valid, out_sum, out_bit, out_beats, out_sat
  );
endinterface

// File: rtl/popcount_acc7.sv
// Binary-neuron accumulator: sums popcounts of XNOR beats over a frame and
// compares the saturated total against the threshold latched at frame start.
module popcount_acc7 #(
  parameter int IN_W  = 7,
  parameter int ACC_W = 8,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  popcount_acc7_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic             in_ready_s;
  logic             accept_s;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] thr_r;
  logic             sat_r;

  logic [ACC_W-1:0] acc_base_s;
  logic [ACC_W:0]   acc_wide_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic             cnt_full_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [ACC_W-1:0] thr_sel_s;
  logic             sat_base_s;
  logic             sat_nxt_s;

  logic             out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_bit_r;
  logic [CNT_W-1:0] out_beats_r;
  logic             out_sat_r;

  // Count of set bits, returned one bit wider than the accumulator so the add can detect overflow.
  function automatic logic [ACC_W:0] popcount(input logic [IN_W-1:0] v);
    logic [ACC_W:0] n;
    n = {(ACC_W+1){1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      n = n + {{ACC_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          state_nxt_s = bus.in_last ? RESULT : ACCUM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESULT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: beats are refused only while a result is pending.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE, ACCUM: in_ready_s = 1'b1;
      RESULT:      in_ready_s = 1'b0;
      default:     in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // A new frame starts from zero; later beats build on the running state.
  always_comb begin
    acc_base_s = acc_r;
    cnt_base_s = cnt_r;
    thr_sel_s  = thr_r;
    sat_base_s = sat_r;
    if (state_r == IDLE) begin
      acc_base_s = {ACC_W{1'b0}};
      cnt_base_s = {CNT_W{1'b0}};
      thr_sel_s  = bus.threshold;
      sat_base_s = 1'b0;
    end else begin
      acc_base_s = acc_r;
      cnt_base_s = cnt_r;
      thr_sel_s  = thr_r;
      sat_base_s = sat_r;
    end
  end

  // Saturating add of this beat's popcount and beat count.
  always_comb begin
    acc_wide_s = {1'b0, acc_base_s} + popcount(bus.in_data);
    cnt_full_s = &cnt_base_s;
    if (acc_wide_s[ACC_W]) begin
      acc_nxt_s = {ACC_W{1'b1}};
    end else begin
      acc_nxt_s = acc_wide_s[ACC_W-1:0];
    end
    if (cnt_full_s) begin
      cnt_nxt_s = cnt_base_s;
    end else begin
      cnt_nxt_s = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    sat_nxt_s = sat_base_s | acc_wide_s[ACC_W] | cnt_full_s;
  end

  // Running frame state and the registered result presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      thr_r       <= {ACC_W{1'b0}};
      sat_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_bit_r   <= 1'b0;
      out_beats_r <= {CNT_W{1'b0}};
      out_sat_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_nxt_s;
        thr_r <= thr_sel_s;
        sat_r <= sat_nxt_s;
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
        thr_r <= thr_r;
        sat_r <= sat_r;
      end
      if (accept_s && bus.in_last) begin
        out_valid_r <= 1'b1;
        out_sum_r   <= acc_nxt_s;
        out_bit_r   <= (acc_nxt_s >= thr_sel_s);
        out_beats_r <= cnt_nxt_s;
        out_sat_r   <= sat_nxt_s;
      end else if ((state_r == RESULT) && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_bit   = out_bit_r;
  assign bus.out_beats = out_beats_r;
  assign bus.out_sat   = out_sat_r;

endmodule

// File: doc/popcount_acc7.md
POPCOUNT_ACC7 -- requirements
Module: popcount_acc7

Interface
REQ-001 Parameter: IN_W, default 7, width of each XNOR product vector consumed per beat.
REQ-002 Parameter: ACC_W, default 8, width of accumulator, threshold and result sum.
REQ-003 Parameter: CNT_W, default 6, width of the beat counter.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  1  upstream XNOR vector present on in_data.
REQ-007 Port: in_data  input  IN_W  XNOR product vector (bit 1 = match, +1 contribution).
REQ-008 Port: in_last  input  1  marks the final beat of a frame; qualified by in_valid.
REQ-009 Port: threshold  input  ACC_W  activation threshold, sampled on the first accepted beat of a frame.
REQ-010 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-011 Port: out_valid  output  1  frame result available.
REQ-012 Port: out_ready  input  1  downstream consumes result.
REQ-013 Port: out_sum  output  ACC_W  total popcount of the frame, saturated.
REQ-014 Port: out_bit  output  1  binary activation: 1 iff out_sum >= latched threshold (unsigned).
REQ-015 Port: out_beats  output  CNT_W  number of beats accepted in the frame, saturated.
REQ-016 Port: out_sat  output  1  set if accumulator or beat counter saturated during the frame.

Function
REQ-017 FSM states IDLE, ACCUM, RESULT; reset state IDLE.
REQ-018 Beat accepted when in_valid && in_ready on a rising clk edge; in_ready = 1 in IDLE and ACCUM, 0 in RESULT.
REQ-019 Per accepted beat, popcount(in_data) (0..IN_W) is added combinationally to the accumulator in the same cycle; no pipeline stage before the add.
REQ-020 IDLE, accepted beat: accumulator loads popcount(in_data), beat counter loads 1, threshold latched; next state ACCUM, or RESULT if in_last=1 (single-beat frame).
REQ-021 ACCUM, accepted beat: accumulator += popcount, beat counter += 1; next state RESULT if in_last=1, else ACCUM.
REQ-022 ACCUM with no accepted beat: all state held; no timeout.
REQ-023 Latency: out_valid asserts exactly one cycle after the edge accepting the in_last beat; out_sum/out_bit/out_beats/out_sat are registered and valid whenever out_valid=1.
REQ-024 RESULT: outputs held stable while out_valid && !out_ready; on out_valid && out_ready, next state IDLE, out_valid deasserts next cycle.
REQ-025 No beat accepted in the cycle out_ready is honoured (in_ready=0 in RESULT); earliest next acceptance is the following cycle.
REQ-026 Accumulator saturates at 2^ACC_W-1; beat counter saturates at 2^CNT_W-1; either saturation sets out_sat for the frame, cleared on next frame start.
REQ-027 Threshold changes after the first beat of a frame have no effect on that frame's out_bit.
REQ-028 in_last with in_valid=0 is ignored; in_data ignored when no beat is accepted.

Reset
REQ-029 rst_n low asynchronously forces IDLE, accumulator=0, beat counter=0, latched threshold=0, out_valid=0, out_sum=0, out_bit=0, out_beats=0, out_sat=0; in_ready=1 after release.
REQ-030 Reset asserted mid-frame or in RESULT discards the partial/pending result; no out_valid follows release until a new frame completes.

Verification
REQ-031 Single beat: in_data=7'b1011001, in_last=1, threshold=4 -> next cycle out_valid=1, out_sum=4, out_bit=1, out_beats=1, out_sat=0.
REQ-032 Three-beat frame: 7'h7F, 7'h00, 7'b0000111 (last), threshold=11 -> out_sum=10, out_bit=0, out_beats=3.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> IDLE next cycle, new beat accepted the cycle after.
REQ-034 Saturation: 40 beats of 7'h7F (ACC_W=8) -> out_sum=255, out_sat=1, out_beats=40.
REQ-035 Threshold change mid-frame: threshold=3 at beat 1, 20 at beat 2; total 5 -> out_bit=1.
REQ-036 Reset mid-frame after 2 beats: rst_n low 1 cycle -> all outputs 0; a new 1-beat frame 7'b0000001 yields out_sum=1, out_beats=1.
